zeroriscy_csr_req_master: RTL and testbench

- Initiator side of the core's SRAM-like CSR port (access/addr/wdata/op -> rdata).
- Accepts CSR requests from a debug/system agent over a valid/ready channel, arbitrates for the CSR port via a grant, and issues exactly one CSR cycle per request.
- Captures the returned old CSR value and returns it over a valid/ready response channel.
- Sits between the debug unit and the core-side CSR port mux.

---
 rtl/zeroriscy_csr_req_master_if.sv | 33 +++
 rtl/zeroriscy_csr_req_master.sv | 115 +++++++++++
 tb/tb_zeroriscy_csr_req_master.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/zeroriscy_csr_req_master_if.sv
// Request/response channels and the core-side CSR port of zeroriscy_csr_req_master.
// master = the request-issuing block, slave = the agent and CSR file around it.
interface zeroriscy_csr_req_master_if;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_op_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        csr_gnt_i;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;

    modport master (
        input  req_valid_i, req_addr_i, req_wdata_i, req_op_i, rsp_ready_i,
               csr_gnt_i, csr_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o
    );

    modport slave (
        output req_valid_i, req_addr_i, req_wdata_i, req_op_i, rsp_ready_i,
               csr_gnt_i, csr_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
               csr_access_o, csr_addr_o, csr_wdata_o, csr_op_o
    );
endinterface

// File: rtl/zeroriscy_csr_req_master.sv
// Issues one CSR port cycle per accepted request and returns the old CSR value.
// Optional address filter in IDLE: define CSR_REQ_ADDR_CHECK_EN.
module zeroriscy_csr_req_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    zeroriscy_csr_req_master_if.master        bus
);
    typedef enum logic [1:0] {
        IDLE,
        ARB,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [11:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [1:0]       op_q;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;
    logic [31:0]      rdata_q, rdata_nxt;
    logic             err_q, err_nxt;
    logic             reject;
    logic             access;

`ifdef CSR_REQ_ADDR_CHECK_EN
    logic addr_known;
    always_comb begin
        addr_known = (bus.req_addr_i == 12'h300) || (bus.req_addr_i == 12'h305) ||
                     (bus.req_addr_i == 12'h341) || (bus.req_addr_i == 12'h342) ||
                     (bus.req_addr_i == 12'hF14) || (bus.req_addr_i[11:5] == 7'b0111100) ||
                     (bus.req_addr_i == 12'h7A0) || (bus.req_addr_i == 12'h7A1);
        reject = !addr_known || ((bus.req_addr_i[11:10] == 2'b11) && (bus.req_op_i != 2'b00));
    end
`else
    assign reject = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        rdata_nxt = rdata_q;
        err_nxt   = err_q;
        case (state)
            IDLE: begin
                if (bus.req_valid_i) begin
                    cnt_nxt = '0;
                    if (reject) begin
                        rdata_nxt = '0;
                        err_nxt   = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = ARB;
                    end
                end
            end
            ARB: begin
                // A grant in the expiry cycle takes priority over the timeout.
                if (bus.csr_gnt_i) begin
                    rdata_nxt = bus.csr_rdata_i;
                    err_nxt   = 1'b0;
                    state_nxt = RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    rdata_nxt = '0;
                    err_nxt   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt_q   <= cnt_nxt;
            rdata_q <= rdata_nxt;
            err_q   <= err_nxt;
            if ((state == IDLE) && bus.req_valid_i) begin
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                op_q    <= bus.req_op_i;
            end
        end
    end

    // Strobe is masked by rst so the CSR file cannot commit on the reset edge.
    assign access           = (state == ARB) && !rst;
    assign bus.req_ready_o  = (state == IDLE);
    assign bus.rsp_valid_o  = (state == RESP);
    assign bus.rsp_rdata_o  = rdata_q;
    assign bus.rsp_err_o    = err_q;
    assign bus.csr_access_o = access;
    assign bus.csr_addr_o   = addr_q;
    assign bus.csr_wdata_o  = wdata_q;
    assign bus.csr_op_o     = access ? op_q : 2'b00;
endmodule

// File: tb/tb_zeroriscy_csr_req_master.sv
// Bench for zeroriscy_csr_req_master: directed table, reset/handshake sequences
// and random transactions checked against a transaction-level CSR model.
module tb_zeroriscy_csr_req_master;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst;
    logic env_init;

    zeroriscy_csr_req_master_if bus();

    zeroriscy_csr_req_master #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // CSR file seen by the DUT, and the bench's own transaction-level copy.
    logic [31:0] mem    [4096];
    logic [31:0] shadow [4096];
    int unsigned access_cnt;
    int unsigned commit_cnt;

    function automatic logic [31:0] csr_next(input logic [11:0] a, input logic [31:0] old,
                                             input logic [1:0] op, input logic [31:0] wd);
        logic [31:0] v;
        case (op)
            2'b01:   v = wd;
            2'b10:   v = old | wd;
            2'b11:   v = old & ~wd;
            default: v = old;
        endcase
        if (a[11:10] == 2'b11)  v = old;
        else if (a == 12'h300)  v = (v & 32'h88) | 32'h1800;
        return v;
    endfunction

    assign bus.csr_rdata_i = mem[bus.csr_addr_o];

    always @(posedge clk) begin
        if (env_init) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
            mem[12'h300] <= 32'h1800;
            mem[12'hF14] <= 32'h3;
            access_cnt   <= 0;
            commit_cnt   <= 0;
        end else if (bus.csr_access_o) begin
            access_cnt <= access_cnt + 1;
            if (bus.csr_gnt_i) begin
                mem[bus.csr_addr_o] <= csr_next(bus.csr_addr_o, mem[bus.csr_addr_o],
                                                bus.csr_op_o, bus.csr_wdata_o);
                commit_cnt <= commit_cnt + 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic model_reject(input logic [11:0] a, input logic [1:0] op);
`ifdef CSR_REQ_ADDR_CHECK_EN
        logic known;
        known = (a inside {12'h300, 12'h305, 12'h341, 12'h342, 12'hF14, 12'h7A0, 12'h7A1}) ||
                (a >= 12'h780 && a <= 12'h79F);
        return !known || (a >= 12'hC00 && op != 2'b00);
`else
        return (a === 12'hxxx) && (op === 2'bxx);
`endif
    endfunction

    // Expected outcome of one request; applies the op to the shadow copy when granted in time.
    task automatic predict(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                           input int gnt_at, output logic [31:0] er, output logic ee, output int ea);
        if (model_reject(a, op)) begin
            er = '0; ee = 1'b1; ea = 0;
        end else if (gnt_at >= 1 && gnt_at <= int'(TO)) begin
            er = shadow[a]; ee = 1'b0; ea = gnt_at;
            shadow[a] = csr_next(a, shadow[a], op, wd);
        end else begin
            er = '0; ee = 1'b1; ea = int'(TO);
        end
    endtask

    // Called and returns just after a falling edge.
    task automatic txn(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input int gnt_at, input int rsp_wait,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_arb);
        int unsigned acc0, com0;
        int lat, arb;
        logic [31:0] r0;
        logic e0;
        acc0 = access_cnt;
        com0 = commit_cnt;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.req_op_i    = op;
        bus.req_wdata_i = wd;
        bus.csr_gnt_i   = 1'b0;
        bus.rsp_ready_i = 1'b0;
        chk("req_ready_idle", 32'(bus.req_ready_o), 1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        lat = 1;
        arb = 0;
        while (!bus.rsp_valid_o && lat <= int'(TO) + 4) begin
            if (bus.csr_access_o) begin
                arb++;
                chk("csr_addr", 32'(bus.csr_addr_o), 32'(a));
                chk("csr_op", 32'(bus.csr_op_o), 32'(op));
                chk("csr_wdata", bus.csr_wdata_o, wd);
                chk("req_ready_arb", 32'(bus.req_ready_o), 0);
                bus.csr_gnt_i = (arb == gnt_at);
            end
            @(negedge clk);
            lat++;
        end
        bus.csr_gnt_i = 1'b0;
        chk("rsp_seen", 32'(bus.rsp_valid_o), 1);
        chk("latency", 32'(lat), 32'(exp_arb + 1));
        chk("arb_cycles", 32'(arb), 32'(exp_arb));
        chk("rsp_rdata", bus.rsp_rdata_o, exp_rdata);
        chk("rsp_err", 32'(bus.rsp_err_o), 32'(exp_err));
        chk("access_in_resp", 32'(bus.csr_access_o), 0);
        chk("op_in_resp", 32'(bus.csr_op_o), 0);
        r0 = bus.rsp_rdata_o;
        e0 = bus.rsp_err_o;
        if (rsp_wait > 0) begin
            bus.req_valid_i = 1'b1;
            bus.req_addr_i  = 12'h342;
            bus.req_op_i    = 2'b01;
            bus.req_wdata_i = 32'h5A5A_5A5A;
        end
        for (int i = 0; i < rsp_wait; i++) begin
            @(negedge clk);
            chk("rsp_valid_hold", 32'(bus.rsp_valid_o), 1);
            chk("rsp_rdata_hold", bus.rsp_rdata_o, r0);
            chk("rsp_err_hold", 32'(bus.rsp_err_o), 32'(e0));
            chk("req_ready_resp", 32'(bus.req_ready_o), 0);
        end
        bus.rsp_ready_i = 1'b1;
        @(negedge clk);
        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b0;
        chk("rsp_valid_drop", 32'(bus.rsp_valid_o), 0);
        chk("req_ready_after", 32'(bus.req_ready_o), 1);
        chk("access_count", access_cnt - acc0, 32'(exp_arb));
        chk("commit_count", commit_cnt - com0, exp_err ? 32'd0 : 32'd1);
        chk("csr_value", mem[a], shadow[a]);
    endtask

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        int          gnt_at;
        int          rsp_wait;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [14];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] er;
        logic        ee;
        int          ea;
        logic [11:0] a;
        logic [1:0]  op;
        logic [31:0] wd;
        int          g, r;

        vecs[0]  = '{12'h300, 2'b00, 32'h0,    1,  0, 32'h0000_1800, 1'b0};
        vecs[1]  = '{12'h300, 2'b01, 32'h8,    1,  5, 32'h0000_1800, 1'b0};
        vecs[2]  = '{12'h300, 2'b00, 32'h0,    2,  0, 32'h0000_1808, 1'b0};
        vecs[3]  = '{12'h341, 2'b01, 32'h100,  1,  0, 32'h0000_0000, 1'b0};
        vecs[4]  = '{12'h341, 2'b10, 32'hF0,   1,  1, 32'h0000_0100, 1'b0};
        vecs[5]  = '{12'h341, 2'b00, 32'h0,    1,  0, 32'h0000_01F0, 1'b0};
        vecs[6]  = '{12'h341, 2'b01, 32'hDEAD, 0,  0, 32'h0000_0000, 1'b1};
        vecs[7]  = '{12'h341, 2'b00, 32'h0,    1,  0, 32'h0000_01F0, 1'b0};
        vecs[8]  = '{12'h341, 2'b11, 32'hF0,   16, 2, 32'h0000_01F0, 1'b0};
        vecs[9]  = '{12'h341, 2'b00, 32'h0,    3,  0, 32'h0000_0100, 1'b0};
        vecs[10] = '{12'hF14, 2'b00, 32'h0,    1,  0, 32'h0000_0003, 1'b0};
`ifdef CSR_REQ_ADDR_CHECK_EN
        vecs[11] = '{12'hF14, 2'b01, 32'h5,    1,  0, 32'h0000_0000, 1'b1};
        vecs[12] = '{12'h123, 2'b00, 32'h0,    1,  0, 32'h0000_0000, 1'b1};
`else
        vecs[11] = '{12'hF14, 2'b01, 32'h5,    1,  0, 32'h0000_0003, 1'b0};
        vecs[12] = '{12'h123, 2'b00, 32'h0,    1,  0, 32'h0000_0000, 1'b0};
`endif
        vecs[13] = '{12'hF14, 2'b00, 32'h0,    1,  0, 32'h0000_0003, 1'b0};

        for (int i = 0; i < 4096; i++) shadow[i] = '0;
        shadow[12'h300] = 32'h1800;
        shadow[12'hF14] = 32'h3;

        rst = 1'b1;
        env_init = 1'b1;
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.req_op_i    = '0;
        bus.rsp_ready_i = 1'b0;
        bus.csr_gnt_i   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(bus.req_ready_o), 1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_rsp_rdata", bus.rsp_rdata_o, 0);
        chk("rst_rsp_err", 32'(bus.rsp_err_o), 0);
        chk("rst_access", 32'(bus.csr_access_o), 0);
        chk("rst_addr", 32'(bus.csr_addr_o), 0);
        chk("rst_wdata", bus.csr_wdata_o, 0);
        chk("rst_op", 32'(bus.csr_op_o), 0);
        rst = 1'b0;
        env_init = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            predict(vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].gnt_at, er, ee, ea);
            txn(vecs[i].addr, vecs[i].op, vecs[i].wdata, vecs[i].gnt_at, vecs[i].rsp_wait,
                vecs[i].exp_rdata, vecs[i].exp_err, ea);
        end

        // Reset while waiting for a grant, with the grant arriving on the reset edge.
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = 12'h341;
        bus.req_op_i    = 2'b01;
        bus.req_wdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        chk("arb_before_rst", 32'(bus.csr_access_o), 1);
        @(negedge clk);
        rst = 1'b1;
        bus.csr_gnt_i = 1'b1;
        #1;
        chk("access_during_rst", 32'(bus.csr_access_o), 0);
        r = int'(commit_cnt);
        @(negedge clk);
        chk("rst_mid_commit", commit_cnt, 32'(r));
        chk("rst_mid_mepc", mem[12'h341], shadow[12'h341]);
        chk("rst_mid_req_ready", 32'(bus.req_ready_o), 1);
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid_o), 0);
        chk("rst_mid_rdata", bus.rsp_rdata_o, 0);
        chk("rst_mid_err", 32'(bus.rsp_err_o), 0);
        chk("rst_mid_access", 32'(bus.csr_access_o), 0);
        chk("rst_mid_addr", 32'(bus.csr_addr_o), 0);
        chk("rst_mid_op", 32'(bus.csr_op_o), 0);
        rst = 1'b0;
        bus.csr_gnt_i = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 9))
                0: a = 12'h300;
                1: a = 12'h305;
                2: a = 12'h341;
                3: a = 12'h342;
                4: a = 12'hF14;
                5: a = 12'h780 + 12'($urandom_range(0, 31));
                6: a = 12'h7A0;
                7: a = 12'h7A1;
                8: a = 12'h123;
                default: a = 12'hC05;
            endcase
            op = 2'($urandom_range(0, 3));
            wd = $urandom;
            r  = int'($urandom_range(0, 19));
            if (r < 14)      g = 1 + (r % 4);
            else if (r < 16) g = int'(TO);
            else if (r < 18) g = 0;
            else             g = int'(TO) - 1;
            predict(a, op, wd, g, er, ee, ea);
            txn(a, op, wd, g, int'($urandom_range(0, 3)), er, ee, ea);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
